// File: rtl/parity_frame_checker_if.sv
// Serial frame bus between a line driver and the parity frame checker.
// Carries the strobed serial input together with the deserialised word and its status flags.
interface parity_frame_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  input_bit;
    logic                  bit_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_error;
    logic                  frame_error;
    logic                  busy;

    modport master (
        output input_bit, bit_valid,
        input  data_out, data_valid, parity_error, frame_error, busy
    );

    modport slave (
        input  input_bit, bit_valid,
        output data_out, data_valid, parity_error, frame_error, busy
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Receives start/data/parity/stop frames one bit per bit_valid strobe, LSB first,
// and reports the parallel word with parity and framing error flags.
module parity_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                            clock,
    input  logic                            reset,
    parity_frame_checker_if.slave           bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                state;
    logic [CW-1:0]         bit_count;
    logic                  running_parity;
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] shift_reg;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  parity_error_q;
    logic                  frame_error_q;
    logic                  busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            bit_count      <= '0;
            running_parity <= 1'b0;
            mismatch       <= 1'b0;
            shift_reg      <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (bus.bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bus.input_bit) begin
                            state          <= DATA;
                            busy_q         <= 1'b1;
                            bit_count      <= '0;
                            running_parity <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Shift right from the MSB so the first data bit lands in bit 0.
                        shift_reg      <= {bus.input_bit, shift_reg[DATA_WIDTH-1:1]};
                        running_parity <= running_parity ^ bus.input_bit;
                        bit_count      <= bit_count + 1'b1;
                        if (bit_count == CW'(DATA_WIDTH - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        mismatch <= bus.input_bit ^ running_parity ^ ODD_PARITY;
                        state    <= STOP;
                    end
                    STOP: begin
                        data_out_q     <= shift_reg;
                        parity_error_q <= mismatch;
                        frame_error_q  <= ~bus.input_bit;
                        data_valid_q   <= 1'b1;
                        if (bus.input_bit) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        // A held-low line must return high before a new start bit counts.
                        if (bus.input_bit) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: an even-parity and an odd-parity checker driven by directed frames.
module tb_parity_frame_checker;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    parity_frame_checker_if #(.DATA_WIDTH(8)) e_if ();
    parity_frame_checker_if #(.DATA_WIDTH(8)) o_if ();

    parity_frame_checker #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dut_even (
        .clock(clock), .reset(reset), .bus(e_if)
    );
    parity_frame_checker #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
        .clock(clock), .reset(reset), .bus(o_if)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected record whenever a checker reports a frame.
    always @(negedge clock) begin
        if (!reset && e_if.data_valid) begin
            if (q_even.size() == 0) begin
                chk("even_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q_even.pop_front();
                chk("even_data", 32'(e_if.data_out), 32'(x.data));
                chk("even_perr", 32'(e_if.parity_error), 32'(x.perr));
                chk("even_ferr", 32'(e_if.frame_error), 32'(x.ferr));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && o_if.data_valid) begin
            if (q_odd.size() == 0) begin
                chk("odd_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q_odd.pop_front();
                chk("odd_data", 32'(o_if.data_out), 32'(x.data));
                chk("odd_perr", 32'(o_if.parity_error), 32'(x.perr));
                chk("odd_ferr", 32'(o_if.frame_error), 32'(x.ferr));
            end
        end
    end

    task automatic strobe(input int which, input logic b);
        @(negedge clock);
        if (which == 0) begin
            e_if.bit_valid = 1'b1; e_if.input_bit = b;
        end else begin
            o_if.bit_valid = 1'b1; o_if.input_bit = b;
        end
        @(negedge clock);
        e_if.bit_valid = 1'b0; e_if.input_bit = 1'b1;
        o_if.bit_valid = 1'b0; o_if.input_bit = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Frame with hand-computed expected parity error; maxgap>0 inserts idle cycles.
    task automatic send_frame(input int which, input logic [7:0] data, input logic par,
                              input logic stop, input int maxgap, input logic exp_perr);
        exp_t x;
        x.data = data; x.perr = exp_perr; x.ferr = ~stop;
        if (which == 0) q_even.push_back(x); else q_odd.push_back(x);
        strobe(which, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
            strobe(which, data[i]);
        end
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
        strobe(which, par);
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
        strobe(which, stop);
    endtask

    initial begin
        logic [7:0] partial;
        e_if.bit_valid = 1'b0; e_if.input_bit = 1'b1;
        o_if.bit_valid = 1'b0; o_if.input_bit = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_data_out", 32'(e_if.data_out), 32'h0);
        chk("rst_data_valid", 32'(e_if.data_valid), 32'h0);
        chk("rst_perr", 32'(e_if.parity_error), 32'h0);
        chk("rst_ferr", 32'(e_if.frame_error), 32'h0);
        chk("rst_busy", 32'(e_if.busy), 32'h0);
        reset = 1'b0;
        idle(2);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        chk("busy_after_a5", 32'(e_if.busy), 32'h0);

        send_frame(0, 8'h07, 1'b0, 1'b1, 0, 1'b1);
        send_frame(0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        send_frame(0, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) strobe(0, 1'b0);
        chk("busy_wait_high", 32'(e_if.busy), 32'h1);
        strobe(0, 1'b1);
        chk("busy_after_wait_high", 32'(e_if.busy), 32'h0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        send_frame(0, 8'h5A, 1'b0, 1'b1, 4, 1'b0);
        idle(2);

        partial = 8'h3B;
        strobe(0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(0, partial[i]);
        @(negedge clock);
        reset = 1'b1;
        e_if.bit_valid = 1'b1; e_if.input_bit = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        e_if.bit_valid = 1'b0;
        chk("busy_after_abort", 32'(e_if.busy), 32'h0);
        chk("valid_after_abort", 32'(e_if.data_valid), 32'h0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        send_frame(1, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        send_frame(1, 8'h01, 1'b1, 1'b1, 0, 1'b1);
        idle(4);

        chk("even_queue_drained", 32'(q_even.size()), 32'd0);
        chk("odd_queue_drained", 32'(q_odd.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Receive side of the serial parity path: accepts a serial frame on input_bit and checks its parity bit against a running XOR of the data bits.
- Frame format: start bit, data bits, parity bit, stop bit.
- Deserialises the data bits (LSB first), checks parity and stop bit, and presents the parallel word with error flags.
- Sits downstream of the serial parity generator; one frame bit is consumed per bit_valid strobe.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (2..32).
- ODD_PARITY, 0, 0 = even parity: the expected parity bit equals the XOR of the data bits, matching the generator's toggle-on-one convention. 1 = odd parity: the expected parity bit is the inverted XOR.

Ports:
- clock  input  1  single design clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- input_bit  input  1  serial line; idles high; sampled only when bit_valid=1.
- bit_valid  input  1  strobe: the current input_bit is the next frame bit.
- data_out  output  DATA_WIDTH  last received word, LSB received first.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity mismatch for the frame reported by data_valid.
- frame_error  output  1  stop bit was 0 for the frame reported by data_valid.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (synchronous, evaluated at the clock edge, highest priority):
  - data_out=0, data_valid=0, parity_error=0, frame_error=0, busy=0.
  - state=IDLE, bit counter=0, running parity=0, shift register=0.
- Reset mid-frame aborts the frame: no data_valid is produced and partial data is discarded.
- Strobe gating: state, counter, shift register and parity change only in cycles with bit_valid=1. Gaps of any length between strobes are legal and hold all state.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: strobe with input_bit=0 (start bit) -> DATA; counter=0, running parity=0. Strobe with input_bit=1 -> stay in IDLE.
  - DATA: each strobe shifts input_bit into the MSB of the shift register and shifts right, so the first data bit ends in bit 0.
    - running parity ^= input_bit; counter++.
    - On the strobe carrying data bit DATA_WIDTH-1 -> PARITY.
  - PARITY: on strobe, mismatch = input_bit XOR running parity XOR ODD_PARITY; latch mismatch internally -> STOP.
  - STOP: on strobe, in the next cycle:
    - data_out = shift register.
    - parity_error = latched mismatch.
    - frame_error = ~input_bit.
    - data_valid = 1 for exactly one cycle.
    - Next state: IDLE if input_bit=1, else WAIT_HIGH.
  - WAIT_HIGH: ignores strobes with input_bit=0. A strobe with input_bit=1 -> IDLE. This prevents a held-low line from being taken as a new start bit.
- Latency: data_valid rises in the cycle after the clock edge that samples the stop-bit strobe.
- Flag hold: data_out, parity_error and frame_error hold their values until the next data_valid; they are only meaningful when qualified by data_valid.
- Back-to-back frames: a start strobe immediately after a good stop strobe is accepted in IDLE with no idle bit required.
- Width rules:
  - Counter width is clog2(DATA_WIDTH)+1; it never wraps within a frame.
  - Parity is a 1-bit XOR accumulation; no arithmetic overflow is possible.
- Simultaneous events: if reset and bit_valid are high in the same cycle, reset wins and the strobe is dropped.

Test Plan:
- Default params. Strobes: 0 | 1,0,1,0,0,1,0,1 | 0 | 1 (byte 0xA5, parity 0) -> data_out=0xA5, data_valid high exactly 1 cycle, parity_error=0, frame_error=0, busy low after.
- Byte 0x07 with parity bit 0 (correct is 1) -> data_out=0x07, parity_error=1, frame_error=0. Next frame 0x00 with parity 0 -> parity_error clears to 0.
- Byte 0x3C with good parity and stop bit 0, then 3 strobes of 0, then a strobe of 1, then frame 0x81 -> first frame frame_error=1. No frame starts during the low strobes; 0x81 received clean.
- Frame 0x5A with 0-4 idle cycles (bit_valid=0) inserted randomly between strobes -> identical result to the gapless frame: data_out=0x5A, single data_valid pulse.
- Reset asserted after the 4th data bit, then released, then full frame 0xFF, parity 0, stop 1 -> no data_valid for the aborted frame; 0xFF received with parity_error=0.
- ODD_PARITY=1, byte 0x01 with parity 0 -> parity_error=0. Same byte with parity 1 -> parity_error=1. Two back-to-back frames with no idle strobe -> two data_valid pulses.
